onewire_slave_responder: RTL and testbench
==========================================

Name: onewire_slave_responder

Overview:
1-Wire slave (responder) for the LED node, the far end of the bus driven by the onewire master controller.
- Detects the master reset pulse and answers with a presence pulse.
- Receives function byte, 56-bit ROM, CRC byte and command byte, all LSB-first.
- On a full address match, latches the command and drives the LED output.
- All timing is derived from clk by cycle counters; dq is open-drain.

Parameters:
ROM_CODE, 56'hFFFFFFFFFFFFFF, 56-bit family+serial this node answers to
CRC_CODE, 8'hAA, expected CRC byte following ROM
RESET_CYC, 20000, minimum dq-low cycles recognised as reset (400 us @ 50 MHz)
PRES_DLY_CYC, 1500, cycles from reset release to presence start (30 us)
PRES_LEN_CYC, 6000, presence pulse length in cycles (120 us)
SAMPLE_CYC, 1500, cycles after a slot falling edge at which the bit is sampled (30 us)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
dq  inout  1  1-Wire bus, open-drain: driven 0 or released (z)
led  output  1  LED state; 1 after command 0xFF, 0 after command 0x00
cmd_valid  output  1  one-cycle pulse when a command byte is accepted
cmd_byte  output  8  last accepted command byte
selected  output  1  high from CRC match until next bus reset
rom_mismatch  output  1  sticky: function/ROM/CRC mismatch since last bus reset
busy  output  1  high from reset detection until command accepted or mismatch

Behaviour:
- Reset and clocking: clock clk; reset rst, asynchronous, active-high. Async reset sets state IDLE and releases dq (z). Reset values: led=0, cmd_valid=0, cmd_byte=8'h00, selected=0, rom_mismatch=0, busy=0.
- Counter widths: all counters 16 bits; every *_CYC parameter must be ≤ 65535.
- Input sampling: dq passes through a 2-flop synchronizer to give dq_s, so 2 cycles of input latency.
  - fall = dq_s 1→0; rise = dq_s 0→1.
- dq drive: dq = drive_low ? 0 : z. drive_low is a register and is asserted only in PRES_PULSE.
- Global reset detector (active in every state except while drive_low=1):
  - low_cnt increments while dq_s=0, saturates at RESET_CYC and clears on dq_s=1.
  - At low_cnt==RESET_CYC: set rst_seen, clear selected/rom_mismatch/bit_cnt, set busy=1.
  - On rise with rst_seen=1: clear rst_seen and enter PRES_DLY.
  - This overrides any state, so a bus reset mid-transaction restarts the sequence.
- Field tracking: field register, one of FUNC(8), ROM(56), CRC(8), CMD(8). bit_cnt counts bits within the current field; shift register shifts right with the sample entering at the MSB.
- States:
  - IDLE: wait for the reset detector.
  - PRES_DLY: count PRES_DLY_CYC cycles → PRES_PULSE.
  - PRES_PULSE: drive_low=1 for exactly PRES_LEN_CYC cycles, then release. Field=FUNC → WAIT_SLOT.
  - WAIT_SLOT: on fall, clear slot counter → SAMPLE.
  - SAMPLE: when slot counter == SAMPLE_CYC-1, shift in dq_s (1 = bit 1) → SLOT_END.
  - SLOT_END: wait for dq_s=1. If the field is complete, compare it; otherwise → WAIT_SLOT.
  - SKIP: ignore all slots until the next bus reset.
- Field comparisons:
  - FUNC ≠ 8'h55, ROM ≠ ROM_CODE, or CRC check fails: rom_mismatch=1, busy=0 → SKIP.
  - CRC match: selected=1.
  - CMD complete: cmd_byte=shift, cmd_valid=1 for one cycle, busy=0 → SKIP.
- LED update on command: 0xFF → led=1; 0x00 → led=0; any other value leaves led unchanged (cmd_valid still pulses).
- Corner cases:
  - A low pulse lasting ≥ RESET_CYC inside a slot is treated as a reset; any partial field is discarded.
  - A fall seen while in SAMPLE is ignored.
  - led holds its value across bus resets; only rst clears it.

Optional Feature:
ONEWIRE_SLAVE_CRC_CHK_EN
- Defined: the CRC byte is compared to CRC_CODE; a mismatch sets rom_mismatch and enters SKIP.
- Undefined: the CRC byte is received and discarded; selected=1 once the 8 CRC bits are received.

Test Plan:
- dq low 24000 cycles then released → dq driven 0 starting PRES_DLY_CYC+2 (±1) cycles after release, for exactly 6000 cycles; busy=1.
- Reset, then 0x55, ROM all-ones, 0xAA, 0xFF → selected=1 after the CRC slot; one cmd_valid pulse; cmd_byte=8'hFF; led=1; busy=0. Repeat with cmd 0x00 → led=0.
- Reset, function 0x33 → rom_mismatch=1; following 72 slots produce no cmd_valid; led unchanged.
- Reset, ROM with bit 20 = 0 → rom_mismatch=1 after the ROM field; selected stays 0.
- Reset, 30 ROM bits, then a 480 us reset → new presence pulse, rom_mismatch/selected cleared; full valid transaction then gives led=1.
- CRC byte 0x00: with ONEWIRE_SLAVE_CRC_CHK_EN defined → rom_mismatch=1, led unchanged; undefined → selected=1, cmd 0xFF sets led=1.

Source files
------------

// File: rtl/onewire_slave_responder_if.sv
// Status interface of the 1-Wire LED-node responder. The open-drain dq wire
// stays a plain inout on the responder so bus resolution happens at the wire itself.
interface onewire_slave_responder_if;
  logic       led;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       selected;
  logic       rom_mismatch;
  logic       busy;

  modport slave  (output led, cmd_valid, cmd_byte, selected, rom_mismatch, busy);
  modport master (input  led, cmd_valid, cmd_byte, selected, rom_mismatch, busy);
endinterface

// File: rtl/onewire_slave_responder.sv
// 1-Wire slave for the LED node: reset/presence, function+ROM+CRC address match, command byte.
// Optional macro ONEWIRE_SLAVE_CRC_CHK_EN: compare the CRC byte against CRC_CODE.
module onewire_slave_responder #(
  parameter logic [55:0] ROM_CODE     = 56'hFF_FFFF_FFFF_FFFF,
`ifdef ONEWIRE_SLAVE_CRC_CHK_EN
  parameter logic [7:0]  CRC_CODE     = 8'hAA,
`endif
  parameter logic [15:0] RESET_CYC    = 16'd20000,
  parameter logic [15:0] PRES_DLY_CYC = 16'd1500,
  parameter logic [15:0] PRES_LEN_CYC = 16'd6000,
  parameter logic [15:0] SAMPLE_CYC   = 16'd1500
) (
  input  logic                       clk,
  input  logic                       rst,
  inout  wire                        dq,
  onewire_slave_responder_if.slave   bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRES_DLY   = 3'd1;
  localparam logic [2:0] S_PRES_PULSE = 3'd2;
  localparam logic [2:0] S_WAIT_SLOT  = 3'd3;
  localparam logic [2:0] S_SAMPLE     = 3'd4;
  localparam logic [2:0] S_SLOT_END   = 3'd5;
  localparam logic [2:0] S_SKIP       = 3'd6;

  localparam logic [1:0] F_FUNC = 2'd0;
  localparam logic [1:0] F_ROM  = 2'd1;
  localparam logic [1:0] F_CRC  = 2'd2;
  localparam logic [1:0] F_CMD  = 2'd3;

  localparam logic [15:0] PRES_DLY_LAST = PRES_DLY_CYC - 16'd1;
  localparam logic [15:0] PRES_LEN_LAST = PRES_LEN_CYC - 16'd1;
  localparam logic [15:0] SAMPLE_LAST   = SAMPLE_CYC - 16'd1;

  logic        dq_meta, dq_s, dq_s_q;
  logic        fall, rise, rst_det;
  logic        drive_low;
  logic [2:0]  state;
  logic [1:0]  field;
  logic [15:0] cnt, low_cnt, bit_cnt, field_len;
  logic [55:0] shift;
  logic        rst_seen;
  logic        led, cmd_valid, selected, rom_mismatch, busy;
  logic [7:0]  cmd_byte;

  assign dq = drive_low ? 1'b0 : 1'bz;

  // Bus idles high, so the synchronizer resets to 1 to avoid a false fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_meta <= 1'b1;
      dq_s    <= 1'b1;
      dq_s_q  <= 1'b1;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
      dq_meta <= dq;
      dq_s    <= dq_meta;
      dq_s_q  <= dq_s;
    end
  end

  assign fall    = dq_s_q & ~dq_s;
  assign rise    = ~dq_s_q & dq_s;
  assign rst_det = !drive_low && !dq_s && (low_cnt == RESET_CYC);

  // Our own presence pulse must never look like a master reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     low_cnt <= '0;
    else if (drive_low || dq_s)  low_cnt <= '0;
    else if (low_cnt != RESET_CYC) low_cnt <= low_cnt + 16'd1;
  end

  always_comb begin
    // NOTE: default first so no path leaves field_len unassigned and infers a latch.
    field_len = 16'd8;
    if (field == F_ROM) field_len = 16'd56;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      field        <= F_FUNC;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rst_seen     <= 1'b0;
      drive_low    <= 1'b0;
      led          <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_byte     <= 8'h00;
      selected     <= 1'b0;
      rom_mismatch <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (rst_det) begin
        rst_seen     <= 1'b1;
        selected     <= 1'b0;
        rom_mismatch <= 1'b0;
        bit_cnt      <= '0;
        busy         <= 1'b1;
        state        <= S_IDLE;
      end else if (rise && rst_seen) begin
        rst_seen <= 1'b0;
        cnt      <= '0;
        state    <= S_PRES_DLY;
      end else begin
        case (state)
          S_PRES_DLY: begin
            if (cnt == PRES_DLY_LAST) begin
              cnt       <= '0;
              drive_low <= 1'b1;
              state     <= S_PRES_PULSE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_PRES_PULSE: begin
            if (cnt == PRES_LEN_LAST) begin
              drive_low <= 1'b0;
              field     <= F_FUNC;
              bit_cnt   <= '0;
              state     <= S_WAIT_SLOT;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_WAIT_SLOT: begin
            if (fall) begin
              cnt   <= '0;
              state <= S_SAMPLE;
            end
          end
          S_SAMPLE: begin
            if (cnt == SAMPLE_LAST) begin
              shift   <= {dq_s, shift[55:1]};
              bit_cnt <= bit_cnt + 16'd1;
              state   <= S_SLOT_END;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_SLOT_END: begin
            if (dq_s) begin
              if (bit_cnt != field_len) begin
                state <= S_WAIT_SLOT;
              end else begin
                bit_cnt <= '0;
                state   <= S_WAIT_SLOT;
                // Fields arrive LSB-first, so a byte field sits in the top 8 bits.
                case (field)
                  F_FUNC: begin
                    if (shift[55:48] != 8'h55) begin
                      rom_mismatch <= 1'b1;
                      busy         <= 1'b0;
                      state        <= S_SKIP;
                    end else begin
                      field <= F_ROM;
                    end
                  end
                  F_ROM: begin
                    if (shift != ROM_CODE) begin
                      rom_mismatch <= 1'b1;
                      busy         <= 1'b0;
                      state        <= S_SKIP;
                    end else begin
                      field <= F_CRC;
                    end
                  end
                  F_CRC: begin
`ifdef ONEWIRE_SLAVE_CRC_CHK_EN
                    if (shift[55:48] != CRC_CODE) begin
                      rom_mismatch <= 1'b1;
                      busy         <= 1'b0;
                      state        <= S_SKIP;
                    end else begin
                      selected <= 1'b1;
                      field    <= F_CMD;
                    end
`else
                    selected <= 1'b1;
                    field    <= F_CMD;
`endif
                  end
                  default: begin
                    cmd_byte  <= shift[55:48];
                    cmd_valid <= 1'b1;
                    busy      <= 1'b0;
                    if (shift[55:48] == 8'hFF)      led <= 1'b1;
                    else if (shift[55:48] == 8'h00) led <= 1'b0;
                    state <= S_SKIP;
                  end
                endcase
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.led          = led;
  assign bus.cmd_valid    = cmd_valid;
  assign bus.cmd_byte     = cmd_byte;
  assign bus.selected     = selected;
  assign bus.rom_mismatch = rom_mismatch;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_onewire_slave_responder.sv
// Self-checking bench for onewire_slave_responder: bit-banged master, transaction-level model.
module tb_onewire_slave_responder;

  localparam logic [15:0] T_RESET  = 16'd200;
  localparam logic [15:0] T_DLY    = 16'd15;
  localparam logic [15:0] T_LEN    = 16'd60;
  localparam logic [15:0] T_SAMPLE = 16'd15;
  localparam logic [55:0] ROM      = 56'hFF_FFFF_FFFF_FFFF;
  localparam int SLOT = 32;
  localparam int LOW0 = 24;
  localparam int LOW1 = 3;
  localparam int RST_LEN = 240;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_low = 1'b0;
  wire  dq;

  pullup (dq);
  assign dq = m_low ? 1'b0 : 1'bz;

  onewire_slave_responder_if bus ();

  onewire_slave_responder #(
    .RESET_CYC   (T_RESET),
    .PRES_DLY_CYC(T_DLY),
    .PRES_LEN_CYC(T_LEN),
    .SAMPLE_CYC  (T_SAMPLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dq (dq),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cv_cnt = 0;
  logic       exp_led = 1'b0;
  logic [7:0] exp_cmd = 8'h00;

  always @(negedge clk) if (bus.cmd_valid) cv_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_reset(input string tag);
    int n;
    int m;
    int dly;
    @(negedge clk) m_low = 1'b1;
    repeat (RST_LEN) @(negedge clk);
    m_low = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (dq == 1'b0) break;
    end
    if (dq != 1'b0) begin
      check({tag, "/pres_seen"}, 64'(dq), 64'(0));
    end else begin
      dly = n - 1;
      check({tag, "/pres_dly"}, 64'(dly),
            (dly >= int'(T_DLY) + 1 && dly <= int'(T_DLY) + 3) ? 64'(dly) : 64'(int'(T_DLY) + 2));
      check({tag, "/busy_pres"}, 64'(bus.busy), 64'(1));
      m = 1;
      while (m < 1000) begin
        @(posedge clk); #1;
        if (dq != 1'b0) break;
        m++;
      end
      check({tag, "/pres_len"}, 64'(m), 64'(T_LEN));
    end
    check({tag, "/sel_clr"},  64'(bus.selected),     64'(0));
    check({tag, "/mism_clr"}, 64'(bus.rom_mismatch), 64'(0));
    repeat (8) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    int lo;
    lo = b ? LOW1 : LOW0;
    @(negedge clk) m_low = 1'b1;
    repeat (lo) @(negedge clk);
    m_low = 1'b0;
    repeat (SLOT - lo) @(negedge clk);
  endtask

  task automatic write_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) write_bit(v[i]);
  endtask

  // Outcome of a full transaction derived from the addressing rules alone.
  task automatic run_txn(input string tag, input logic [7:0] func, input logic [55:0] rom,
                         input logic [7:0] crc, input logic [7:0] cmd);
    logic func_ok, rom_ok, crc_ok, acc;
    int   cv0;
    func_ok = (func == 8'h55);
    rom_ok  = (rom == ROM);
`ifdef ONEWIRE_SLAVE_CRC_CHK_EN
    crc_ok  = (crc == 8'hAA);
`else
    crc_ok  = 1'b1;
`endif
    acc = func_ok && rom_ok && crc_ok;
    bus_reset(tag);
    cv0 = cv_cnt;
    write_bits(64'(func), 8);
    check({tag, "/mism_func"}, 64'(bus.rom_mismatch), 64'(!func_ok));
    write_bits(64'(rom), 56);
    check({tag, "/mism_rom"}, 64'(bus.rom_mismatch), 64'(!(func_ok && rom_ok)));
    write_bits(64'(crc), 8);
    check({tag, "/sel_crc"}, 64'(bus.selected), 64'(acc));
    write_bits(64'(cmd), 8);
    if (acc) begin
      exp_cmd = cmd;
      if (cmd == 8'hFF)      exp_led = 1'b1;
      else if (cmd == 8'h00) exp_led = 1'b0;
    end
    check({tag, "/mism_end"},  64'(bus.rom_mismatch), 64'(!acc));
    check({tag, "/cv_pulses"}, 64'(cv_cnt - cv0),     64'(acc));
    check({tag, "/cmd_byte"},  64'(bus.cmd_byte),     64'(exp_cmd));
    check({tag, "/led"},       64'(bus.led),          64'(exp_led));
    check({tag, "/busy_end"},  64'(bus.busy),         64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  f, c, k;
    logic [55:0] r;
    int kind;

    repeat (3) @(negedge clk);
    check("rst/led",       64'(bus.led),          64'(0));
    check("rst/cmd_valid", 64'(bus.cmd_valid),    64'(0));
    check("rst/cmd_byte",  64'(bus.cmd_byte),     64'(0));
    check("rst/selected",  64'(bus.selected),     64'(0));
    check("rst/mismatch",  64'(bus.rom_mismatch), 64'(0));
    check("rst/busy",      64'(bus.busy),         64'(0));
    check("rst/dq",        64'(dq),               64'(1));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_txn("led_on",  8'h55, ROM, 8'hAA, 8'hFF);
    run_txn("led_off", 8'h55, ROM, 8'hAA, 8'h00);
    run_txn("func33",  8'h33, ROM, 8'hAA, 8'hFF);
    run_txn("rom_b20", 8'h55, ROM & ~(56'd1 << 20), 8'hAA, 8'hFF);

    bus_reset("abort");
    write_bits(64'h55, 8);
    write_bits(64'h0, 30);
    run_txn("after_abort", 8'h55, ROM, 8'hAA, 8'hFF);

    run_txn("pre_crc", 8'h55, ROM, 8'hAA, 8'h00);
    run_txn("crc00",   8'h55, ROM, 8'h00, 8'hFF);

    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 2))
        0:       k = 8'hFF;
        1:       k = 8'h00;
        default: k = 8'($urandom);
      endcase
      f = 8'h55;
      r = ROM;
      c = 8'hAA;
      if (kind == 1) begin
        f = 8'($urandom);
        if (f == 8'h55) f = 8'h33;
      end
      if (kind == 2) r = ROM ^ (56'd1 << $urandom_range(0, 55));
      if (kind == 3) begin
        c = 8'($urandom);
        if (c == 8'hAA) c = 8'h5A;
      end
      run_txn($sformatf("rnd%0d", i), f, r, c, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
